// File: rtl/sprite_sched.sv
// sprite_sched: frame-driven position sequencer and priority pixel arbiter
// for a bank of NSPR sprites sharing one CLUT.
// Optional feature: define SPRITE_SCHED_BOUNCE_EN to bounce sprites off the
// screen edges (clamp X, negate VX) instead of wrapping them around.

// Per-sprite position/velocity registers and edge handling.
module sprite_lane #(
    parameter int CORDW     = 12,
    parameter int H_RES     = 1024,
    parameter int SPR_DRAWW = 128,
    parameter int INIT_X    = 1024,
    parameter int INIT_Y    = 240,
    parameter int INIT_VX   = -2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd,
    input  logic             wr_x,
    input  logic             wr_y,
    input  logic             wr_vx,
    input  logic [CORDW-1:0] wr_data,
    output logic [CORDW-1:0] x,
    output logic [CORDW-1:0] y
);
    localparam logic signed [CORDW:0] LIM_L   = (CORDW+1)'(-SPR_DRAWW);
    localparam logic signed [CORDW:0] LIM_R   = (CORDW+1)'(H_RES);
    localparam logic [CORDW-1:0]      X_LEFT  = CORDW'(1 - SPR_DRAWW);
    localparam logic [CORDW-1:0]      X_RIGHT = CORDW'(H_RES);

    logic [CORDW-1:0]        vx;
    logic signed [CORDW:0]   nx;
    logic                    at_left;
    logic                    at_right;

    // next X one bit wider so the edge tests cannot overflow
    always_comb begin
        nx       = $signed({x[CORDW-1], x}) + $signed({vx[CORDW-1], vx});
        at_left  = (nx <= LIM_L);
        at_right = (nx > LIM_R);
    end

    // register update: config write beats the sequencer on the same field
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x  <= CORDW'(INIT_X);
            y  <= CORDW'(INIT_Y);
            vx <= CORDW'(INIT_VX);
        end else begin
            if (wr_x)
                x <= wr_data;
            else if (upd) begin
`ifdef SPRITE_SCHED_BOUNCE_EN
                if (at_left)       x <= X_LEFT;
                else if (at_right) x <= X_RIGHT;
                else               x <= nx[CORDW-1:0];
`else
                if (at_left)       x <= X_RIGHT;
                else if (at_right) x <= X_LEFT;
                else               x <= nx[CORDW-1:0];
`endif
            end
            if (wr_y)
                y <= wr_data;
            if (wr_vx)
                vx <= wr_data;
`ifdef SPRITE_SCHED_BOUNCE_EN
            else if (upd && (at_left || at_right))
                vx <= -vx;
`endif
        end
    end
endmodule

module sprite_sched #(
    parameter int NSPR       = 4,
    parameter int CORDW      = 12,
    parameter int CIDXW      = 4,
    parameter int H_RES      = 1024,
    parameter int SPR_DRAWW  = 128,
    parameter int TRANS_INDX = 9,
    parameter int INIT_X     = 1024,
    parameter int INIT_Y     = 240,
    parameter int INIT_VX    = -2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_idx,
    input  logic [1:0]            cfg_sel,
    input  logic [CORDW-1:0]      cfg_data,
    input  logic [NSPR-1:0]       spr_drawing,
    input  logic [NSPR*CIDXW-1:0] spr_pix,
    output logic [NSPR*CORDW-1:0] sprx,
    output logic [NSPR*CORDW-1:0] spry,
    output logic [CIDXW-1:0]      pix,
    output logic                  drawing,
    output logic                  busy,
    output logic                  overrun
);
    localparam logic [CIDXW-1:0] TRANS    = CIDXW'(TRANS_INDX);
    localparam logic [3:0]       LAST_IDX = 4'(NSPR - 1);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [CIDXW-1:0] win_pix;
    logic             win_any;

    // one lane per sprite; cfg_idx >= NSPR matches no lane and is dropped
    for (genvar i = 0; i < NSPR; i++) begin : g_lane
        sprite_lane #(
            .CORDW(CORDW), .H_RES(H_RES), .SPR_DRAWW(SPR_DRAWW),
            .INIT_X(INIT_X), .INIT_Y(INIT_Y), .INIT_VX(INIT_VX)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .upd    (state == UPDATE && idx == 4'(i)),
            .wr_x   (cfg_we && cfg_sel == 2'd0 && cfg_idx == 4'(i)),
            .wr_y   (cfg_we && cfg_sel == 2'd1 && cfg_idx == 4'(i)),
            .wr_vx  (cfg_we && cfg_sel == 2'd2 && cfg_idx == 4'(i)),
            .wr_data(cfg_data),
            .x      (sprx[i*CORDW +: CORDW]),
            .y      (spry[i*CORDW +: CORDW])
        );
    end

    // update sequencer: one sprite per cycle after a frame pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: if (frame) begin
                    state <= UPDATE;
                    idx   <= '0;
                    busy  <= 1'b1;
                end
                UPDATE: begin
                    if (frame)
                        overrun <= 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // priority pick: scan high to low so the lowest opaque sprite is left
    always_comb begin
        win_pix = TRANS;
        win_any = 1'b0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (spr_drawing[i] && spr_pix[i*CIDXW +: CIDXW] != TRANS) begin
                win_pix = spr_pix[i*CIDXW +: CIDXW];
                win_any = 1'b1;
            end
        end
    end

    // arbiter output register, one cycle behind the sprite pixels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix     <= TRANS;
            drawing <= 1'b0;
        end else begin
            pix     <= win_pix;
            drawing <= win_any;
        end
    end
endmodule

// File: tb/tb_sprite_sched.sv
// tb_sprite_sched: directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_sprite_sched;
    localparam int NSPR  = 4;
    localparam int CORDW = 12;
    localparam int CIDXW = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  frame;
    logic                  cfg_we;
    logic [3:0]            cfg_idx;
    logic [1:0]            cfg_sel;
    logic [CORDW-1:0]      cfg_data;
    logic [NSPR-1:0]       spr_drawing;
    logic [NSPR*CIDXW-1:0] spr_pix;
    logic [NSPR*CORDW-1:0] sprx;
    logic [NSPR*CORDW-1:0] spry;
    logic [CIDXW-1:0]      pix;
    logic                  drawing;
    logic                  busy;
    logic                  overrun;

    int n_vec = 0;
    int n_err = 0;

    sprite_sched dut (
        .clk(clk), .rst_n(rst_n), .frame(frame), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .spr_drawing(spr_drawing), .spr_pix(spr_pix), .sprx(sprx),
        .spry(spry), .pix(pix), .drawing(drawing), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int getx(input int i);
        return int'($signed(sprx[i*CORDW +: CORDW]));
    endfunction

    function automatic int gety(input int i);
        return int'($signed(spry[i*CORDW +: CORDW]));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_wr(input int idx, input int sel, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = 4'(idx);
        cfg_sel  = 2'(sel);
        cfg_data = CORDW'(data);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // pulse frame for one cycle and let the 4-sprite sequence finish
    task automatic run_frame();
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        tick(4);
    endtask

    initial begin
        rst_n = 1'b0; frame = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_sel = '0; cfg_data = '0; spr_drawing = '0; spr_pix = '0;
        tick(2);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_pix", int'(pix), 9);
        check("rst_drawing", int'(drawing), 0);
        check("rst_x3", getx(3), 1024);
        check("rst_y0", gety(0), 240);
        rst_n = 1'b1;

        // 1: one frame -> busy for 4 cycles, every X moves by -2
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("t1_busy_c%0d", c), int'(busy), 1);
            if (c < 3) @(negedge clk);
        end
        @(negedge clk);
        check("t1_busy_end", int'(busy), 0);
        for (int i = 0; i < NSPR; i++) begin
            check($sformatf("t1_x%0d", i), getx(i), 1022);
            check($sformatf("t1_y%0d", i), gety(i), 240);
        end
        check("t1_overrun", int'(overrun), 0);

        // 2: left edge (X0=-126, VX0=-2), then right edge (X1=1023, VX1=+2)
        cfg_wr(0, 0, -126);
        run_frame();
`ifdef SPRITE_SCHED_BOUNCE_EN
        check("t2_x0_left", getx(0), -127);
`else
        check("t2_x0_left", getx(0), 1024);
`endif
        check("t2_x1_mid", getx(1), 1020);
        cfg_wr(1, 0, 1023);
        cfg_wr(1, 2, 2);
        cfg_wr(7, 0, 55);   // out-of-range sprite: dropped
        cfg_wr(2, 3, 77);   // reserved field: dropped
        run_frame();
`ifdef SPRITE_SCHED_BOUNCE_EN
        check("t2_x0_after", getx(0), -125);
        check("t2_x1_right", getx(1), 1024);
`else
        check("t2_x0_after", getx(0), 1022);
        check("t2_x1_right", getx(1), -127);
`endif
        check("t2_x2_plain", getx(2), 1018);

        // 3: second frame two cycles into the sequence -> ignored, overrun sticky
        cfg_wr(2, 0, 600);
        cfg_wr(2, 1, 100);
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        tick(2);
        check("t3_busy_end", int'(busy), 0);
        check("t3_overrun", int'(overrun), 1);
        check("t3_x2_once", getx(2), 598);
        check("t3_y2", gety(2), 100);
        tick(6);
        check("t3_no_restart", getx(2), 598);
        check("t3_overrun_held", int'(overrun), 1);

        // 4: X write to sprite 1 in the cycle it is updated -> write wins
        @(negedge clk);
        frame = 1'b1;                  // sequence enters UPDATE at next edge
        @(negedge clk);
        frame = 1'b0;                  // sprite 0 updates at next edge
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 4'd1; cfg_sel = 2'd0; cfg_data = CORDW'(500);
        @(negedge clk);                // sprite 1 updated at the edge just passed
        cfg_we = 1'b0;
        tick(2);
        check("t4_x1_write", getx(1), 500);
        check("t4_x2_moved", getx(2), 596);

        // 5: arbiter
        @(negedge clk);
        spr_drawing = 4'b0110;
        spr_pix = {4'd7, 4'd5, 4'd9, 4'd3};
        @(negedge clk);
        check("t5_pix_a", int'(pix), 5);
        check("t5_drw_a", int'(drawing), 1);
        spr_drawing = 4'b0000;
        @(negedge clk);
        check("t5_pix_b", int'(pix), 9);
        check("t5_drw_b", int'(drawing), 0);
        spr_drawing = 4'b1111;
        spr_pix = {4'd7, 4'd5, 4'd9, 4'd2};
        @(negedge clk);
        check("t5_pix_c", int'(pix), 2);
        spr_drawing = 4'b1000;
        spr_pix = {4'd9, 4'd5, 4'd1, 4'd2};
        @(negedge clk);
        check("t5_pix_d", int'(pix), 9);
        check("t5_drw_d", int'(drawing), 0);

        // 6: reset while sprite 2 is being updated
        spr_drawing = 4'b0001;
        spr_pix = {4'd7, 4'd5, 4'd9, 4'd3};
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        tick(2);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_busy", int'(busy), 0);
        check("t6_overrun", int'(overrun), 0);
        check("t6_x1", getx(1), 1024);
        check("t6_x2", getx(2), 1024);
        check("t6_y2", gety(2), 240);
        check("t6_pix", int'(pix), 9);
        check("t6_drawing", int'(drawing), 0);
        rst_n = 1'b1;
        run_frame();
        check("t6_x0_resume", getx(0), 1022);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
